// File: rtl/afg_pkg.sv
// Shared definitions for the arbitrary-function-generator blocks:
// default data width, FSM state type and default DAC output codes.
package afg_pkg;

    localparam int DEF_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DEF_W-1:0] DEF_HIGH_CODE = 12'hFFF;
    localparam logic [DEF_W-1:0] DEF_LOW_CODE  = 12'h000;

endpackage

// File: rtl/pwm_phase_cnt.sv
// Phase counter for the pulse generator: advances on Tick, wraps to zero at
// the supplied terminal value (Pe-1) and flags the wrapping edge.
module pwm_phase_cnt
    import afg_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         tick,
    input  logic         clear,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         wrap
);

    // A clear request overrides any wrap so that leaving RUN is never a cycle completion
    assign wrap = tick && !clear && (count == terminal);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/pulse_wave_gen.sv
// Pulse/square-wave generator: shadowed period/duty, glitch-free updates at
// period boundaries, registered pulse level and DAC sample code.
module pulse_wave_gen
    import afg_pkg::*;
#(
    parameter int           W         = DEF_W,
    parameter logic [W-1:0] HIGH_CODE = DEF_HIGH_CODE,
    parameter logic [W-1:0] LOW_CODE  = DEF_LOW_CODE
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Enable,
    input  logic         Tick,
    input  logic [W-1:0] Period,
    input  logic [W-1:0] Duty,
    input  logic         Update,
    output logic         PulseOut,
    output logic [W-1:0] Dout,
    output logic         CycleDone,
    output logic         Pending
);

    state_t       state;
    logic [W-1:0] sh_period;
    logic [W-1:0] sh_duty;
    logic [W-1:0] eff_period;
    logic [W-1:0] terminal;
    logic [W-1:0] count;
    logic [W-1:0] count_after;
    logic [W-1:0] duty_after;
    logic         wrap;
    logic         clear;
    logic         load_at_wrap;
    logic         level_next;

    // Periods of 0 or 1 would make a degenerate counter, so they run as 2
    assign eff_period   = (sh_period < W'(2)) ? W'(2) : sh_period;
    assign terminal     = eff_period - W'(1);
    assign clear        = (state == IDLE) || !Enable;
    assign load_at_wrap = wrap && (Pending || Update);

    pwm_phase_cnt #(
        .W(W)
    ) u_phase_cnt (
        .Clock   (Clock),
        .Reset   (Reset),
        .tick    (Tick),
        .clear   (clear),
        .terminal(terminal),
        .count   (count),
        .wrap    (wrap)
    );

    // Level is registered, so it is derived from the count and duty in force after this edge
    always_comb begin
        count_after = count;
        if (wrap) begin
            count_after = '0;
        end else if (Tick) begin
            count_after = count + W'(1);
        end
        duty_after = load_at_wrap ? Duty : sh_duty;
        level_next = (count_after < duty_after);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            sh_period <= '0;
            sh_duty   <= '0;
            PulseOut  <= 1'b0;
            Dout      <= LOW_CODE;
            CycleDone <= 1'b0;
            Pending   <= 1'b0;
        end else begin
            CycleDone <= 1'b0;
            case (state)
                IDLE: begin
                    Pending  <= 1'b0;
                    PulseOut <= 1'b0;
                    Dout     <= LOW_CODE;
                    if (Enable) begin
                        state     <= RUN;
                        sh_period <= Period;
                        sh_duty   <= Duty;
                        PulseOut  <= (Duty != '0);
                        Dout      <= (Duty != '0) ? HIGH_CODE : LOW_CODE;
                    end
                end
                RUN: begin
                    if (!Enable) begin
                        state    <= IDLE;
                        PulseOut <= 1'b0;
                        Dout     <= LOW_CODE;
                        Pending  <= 1'b0;
                    end else begin
                        PulseOut  <= level_next;
                        Dout      <= level_next ? HIGH_CODE : LOW_CODE;
                        CycleDone <= wrap;
                        // An Update landing on the wrap edge is applied at once and never pends
                        if (load_at_wrap) begin
                            sh_period <= Period;
                            sh_duty   <= Duty;
                            Pending   <= 1'b0;
                        end else if (Update) begin
                            Pending <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Self-checking bench for pulse_wave_gen: directed scenarios plus random
// stimulus compared every cycle against a period/position reference model.
module tb_pulse_wave_gen;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Tick;
    logic [11:0] Period;
    logic [11:0] Duty;
    logic        Update;
    logic        PulseOut;
    logic [11:0] Dout;
    logic        CycleDone;
    logic        Pending;

    int checks = 0;
    int errors = 0;

    bit m_run;
    int m_pos;
    int m_per;
    int m_duty;
    bit m_pend;
    bit m_pulse;
    bit m_done;

    always #5 Clock = ~Clock;

    pulse_wave_gen dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Enable   (Enable),
        .Tick     (Tick),
        .Period   (Period),
        .Duty     (Duty),
        .Update   (Update),
        .PulseOut (PulseOut),
        .Dout     (Dout),
        .CycleDone(CycleDone),
        .Pending  (Pending)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: position within the current period, advanced modulo the effective period
    task automatic modelStep();
        int pe;
        bit wrapped;
        m_done = 1'b0;
        if (!Reset) begin
            m_run = 0; m_pos = 0; m_per = 0; m_duty = 0; m_pend = 0; m_pulse = 0;
        end else if (!m_run) begin
            m_pend  = 0;
            m_pos   = 0;
            m_pulse = 0;
            if (Enable) begin
                m_run   = 1;
                m_per   = int'(Period);
                m_duty  = int'(Duty);
                m_pulse = (m_pos < m_duty);
            end
        end else if (!Enable) begin
            m_run = 0; m_pos = 0; m_pend = 0; m_pulse = 0;
        end else begin
            wrapped = 0;
            if (Tick) begin
                pe      = (m_per < 2) ? 2 : m_per;
                m_pos   = (m_pos + 1) % pe;
                wrapped = (m_pos == 0);
                m_done  = wrapped;
            end
            if (wrapped && (m_pend || Update)) begin
                m_per  = int'(Period);
                m_duty = int'(Duty);
                m_pend = 0;
            end else if (Update) begin
                m_pend = 1;
            end
            m_pulse = (m_pos < m_duty);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit tk, input bit up,
                                 input int per, input int dty);
        @(negedge Clock);
        Reset  = rst;
        Enable = en;
        Tick   = tk;
        Update = up;
        Period = per[11:0];
        Duty   = dty[11:0];
        @(posedge Clock);
        modelStep();
        #1;
        checkOutput("PulseOut", 32'(PulseOut), 32'(m_pulse));
        checkOutput("Dout", 32'(Dout), m_pulse ? 32'hFFF : 32'h000);
        checkOutput("CycleDone", 32'(CycleDone), 32'(m_done));
        checkOutput("Pending", 32'(Pending), 32'(m_pend));
    endtask

    initial begin
        Reset = 1'b0; Enable = 1'b1; Tick = 1'b1; Update = 1'b0; Period = '0; Duty = '0;

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 10, 3);

        for (int i = 0; i < 35; i++) applyStimulus(1, 1, 1, 0, 10, 3);

        applyStimulus(1, 1, 1, 1, 4, 1);
        for (int i = 0; i < 30; i++) applyStimulus(1, 1, 1, 0, 4, 1);

        applyStimulus(1, 1, 1, 1, 6, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 0, 6, 0);
        applyStimulus(1, 1, 1, 1, 8, 12);
        for (int i = 0; i < 24; i++) applyStimulus(1, 1, 1, 0, 8, 12);
        applyStimulus(1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, 0, 0, 1);

        applyStimulus(1, 1, 1, 1, 5, 2);
        for (int i = 0; i < 60; i++) applyStimulus(1, 1, (i % 3) == 0, 0, 5, 2);

        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 7, 2);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 1, 0, 7, 2);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, 0, 7, 2);
        applyStimulus(0, 1, 1, 1, 9, 4);
        for (int i = 0; i < 12; i++) applyStimulus(1, 1, 1, 0, 9, 4);

        for (int i = 0; i < 4000; i++) begin
            bit rst;
            bit en;
            bit tk;
            bit up;
            int per;
            int dty;
            rst = ($urandom_range(0, 499) != 0);
            en  = ($urandom_range(0, 99) < 95);
            tk  = ($urandom_range(0, 2) != 0);
            up  = ($urandom_range(0, 19) == 0);
            per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
            dty = int'($urandom_range(0, 14));
            applyStimulus(rst, en, tk, up, per, dty);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_wave_gen.md
# pulse_wave_gen

Pulse/square-wave generator that consumes the 12-bit duty value held by the duty register stage and the matching period value, and produces a registered pulse level plus a 12-bit DAC sample code. Sits directly downstream of the duty/period holding registers and upstream of the DAC output mux. New duty/period values are taken into shadow registers only at a cycle boundary, so waveforms never glitch mid-period.

## Interface
- W, 12: data width of period, duty, count and sample code
- HIGH_CODE, 12'hFFF: Dout value while pulse is high
- LOW_CODE, 12'h000: Dout value while pulse is low
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- Enable  in  1  1 = run generator, 0 = idle
- Tick  in  1  sample strobe from clock divider, one Clock wide
- Period  in  W  cycle length in Ticks
- Duty  in  W  high time in Ticks
- Update  in  1  one-cycle request to adopt Period/Duty at next boundary
- PulseOut  out  1  registered pulse level
- Dout  out  W  registered sample code: HIGH_CODE or LOW_CODE
- CycleDone  out  1  one-cycle strobe on each period wrap
- Pending  out  1  Update accepted, not yet applied

## Operation
- States: IDLE, RUN.
- Reset (Reset==0 at Clock edge): state IDLE, count 0, shadow period 0, shadow duty 0, PulseOut 0, Dout LOW_CODE, CycleDone 0, Pending 0. Reset wins over all other inputs.
- IDLE: PulseOut 0, Dout LOW_CODE, count 0. Enable==1 -> load shadows from Period/Duty directly, clear Pending, go RUN with count 0.
- RUN, Enable==0: go IDLE next edge, PulseOut 0, Pending cleared; no cycle completion.
- RUN, Tick==1: if count == Pe-1, count -> 0, CycleDone 1, and if Pending (or Update this cycle) load shadows and clear Pending; else count+1.
- Effective period Pe = max(shadow period, 2). Period 0 or 1 behaves as 2.
- Level: high when count < shadow duty. Duty 0 -> always low; Duty >= Pe -> always high.
- Update in RUN sets Pending; Period/Duty sampled at the wrap edge, not at Update time. Update in IDLE ignored (values load on enable).
- Update coincident with wrap: applied at that wrap, Pending stays 0.
- Tick==0: count, level, shadows hold.
- All counter arithmetic W bits unsigned; count never exceeds Pe-1.

## Timing
- PulseOut/Dout registered; reflect the count value present after the same edge (level computed from next count), i.e. one Clock after the Tick edge that changes count.
- First RUN sample: edge that enters RUN already drives level for count 0 (high if loaded duty > 0).
- CycleDone high for exactly the Clock following a wrap edge.
- New shadows affect level starting with count 0 of the new period.
- Enable drop: PulseOut 0 on the next edge.

## Structure
- Shared package afg_pkg: W default (12), state enum {IDLE, RUN}, HIGH_CODE/LOW_CODE defaults.
- One sub-module pwm_phase_cnt: W-bit counter with Tick enable, clear, and terminal-count compare against Pe-1; outputs count and wrap. Top holds FSM, shadows, Pending, level compare and output registers.

## Test plan
- Reset low for 3 Clocks with Enable=1, Tick=1 -> PulseOut 0, Dout 12'h000, CycleDone 0, Pending 0.
- Enable=1, Period=10, Duty=3, Tick every Clock -> PulseOut high 3 Ticks, low 7, CycleDone every 10 Clocks, Dout toggles 12'hFFF/12'h000.
- Mid-period Update with Period=4, Duty=1 -> Pending 1 until wrap; old 10/3 cycle completes, then 1 high/3 low; Pending 0 after wrap.
- Duty=0 -> PulseOut never high; Duty=12, Period=8 -> always high; Period=0, Duty=1 -> 1 high/1 low.
- Tick every 3rd Clock, Period=5, Duty=2 -> level changes only one Clock after Tick edges; CycleDone every 15 Clocks.
- Enable dropped mid-period, and Reset asserted mid-RUN -> next edge PulseOut 0, IDLE; re-enable restarts at count 0 with current Period/Duty.
